// File: rtl/mac_pkg.sv
// Shared types, default widths and saturation bounds for the output-stationary MAC PE.
package mac_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  localparam int SAT_W_MAX  = 128;

  typedef logic [DEF_DATA_W-1:0] operand_t;
  typedef logic [DEF_ACC_W-1:0]  acc_t;
  typedef logic [SAT_W_MAX-1:0]  sat_bound_t;

  // Largest representable value of a w-bit accumulator; caller truncates to w bits.
  function automatic sat_bound_t sat_max(input int w, input bit sgn);
    sat_bound_t ones;
    ones = '1;
    return sgn ? (ones >> (SAT_W_MAX - w + 1)) : (ones >> (SAT_W_MAX - w));
  endfunction

  function automatic sat_bound_t sat_min(input int w, input bit sgn);
    sat_bound_t one;
    one = sat_bound_t'(1);
    return sgn ? (one << (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/mac_mul.sv
// Signed/unsigned multiplier widened to the accumulator; optional output register
// (MUL_PIPE) carries fire/first alongside the product so they stay aligned.
module mac_mul
  import mac_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SIGNED   = 1,
  parameter int MUL_PIPE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_fire,
  input  logic              i_first,
  output logic [ACC_W-1:0]  o_prod,
  output logic              o_fire,
  output logic              o_first
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] w_prod_s;
  logic [PW-1:0]        w_prod_u;
  logic [ACC_W-1:0]     w_prod_ext;

  assign w_prod_s   = PW'($signed(i_a)) * PW'($signed(i_b));
  assign w_prod_u   = PW'(i_a) * PW'(i_b);
  assign w_prod_ext = (SIGNED != 0) ? ACC_W'(w_prod_s) : ACC_W'(w_prod_u);

  if (MUL_PIPE != 0) begin : g_pipe
    logic [ACC_W-1:0] r_prod;
    logic             r_fire;
    logic             r_first;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_prod  <= '0;
        r_fire  <= 1'b0;
        r_first <= 1'b0;
      end else if (ce) begin
        r_prod  <= w_prod_ext;
        r_fire  <= i_fire;
        r_first <= i_first;
      end
    end

    assign o_prod  = r_prod;
    assign o_fire  = r_fire;
    assign o_first = r_first;
  end else begin : g_comb
    assign o_prod  = w_prod_ext;
    assign o_fire  = i_fire;
    assign o_first = i_first;
  end

endmodule

// File: rtl/mac_pe_os.sv
// Output-stationary systolic MAC PE: 1-cycle operand forwarding, MUL_PIPE-cycle accumulate, column drain.
// Build option MAC_SAT_EN: saturating accumulate with sticky ovf; otherwise wrap and ovf stays 0.
module mac_pe_os
  import mac_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SIGNED   = 1,
  parameter int MUL_PIPE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [DATA_W-1:0] north_in,
  input  logic              north_vld,
  input  logic [DATA_W-1:0] west_in,
  input  logic              west_vld,
  input  logic              west_first,
  output logic [DATA_W-1:0] south_out,
  output logic              south_vld,
  output logic [DATA_W-1:0] east_out,
  output logic              east_vld,
  output logic              east_first,
  input  logic              cap,
  input  logic              drain_shift,
  input  logic [ACC_W-1:0]  drain_in,
  output logic [ACC_W-1:0]  result,
  output logic              ovf
);

  logic [DATA_W-1:0] r_south;
  logic              r_south_vld;
  logic [DATA_W-1:0] r_east;
  logic              r_east_vld;
  logic              r_east_first;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic [ACC_W-1:0]  r_result;

  logic              w_fire;
  logic [ACC_W-1:0]  w_prod;
  logic              w_acc_fire;
  logic              w_acc_first;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_ovf_nxt;
  logic [ACC_W-1:0]  w_sum_sat;
  logic              w_sum_ovf;

  assign w_fire = ce & north_vld & west_vld;

  mac_mul #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .MUL_PIPE(MUL_PIPE)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .i_a    (north_in),
    .i_b    (west_in),
    .i_fire (w_fire),
    .i_first(west_first),
    .o_prod (w_prod),
    .o_fire (w_acc_fire),
    .o_first(w_acc_first)
  );

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(ACC_W, SIGNED != 0));
  localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(ACC_W, SIGNED != 0));

  logic             w_acc_sx;
  logic             w_prod_sx;
  logic [ACC_W:0]   w_sum;

  // One guard bit: sign copy for signed mode, carry-out for unsigned mode.
  assign w_acc_sx  = (SIGNED != 0) && r_acc[ACC_W-1];
  assign w_prod_sx = (SIGNED != 0) && w_prod[ACC_W-1];
  assign w_sum     = {w_acc_sx, r_acc} + {w_prod_sx, w_prod};
  assign w_sum_ovf = (SIGNED != 0) ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
  assign w_sum_sat = !w_sum_ovf ? w_sum[ACC_W-1:0] :
                     ((SIGNED != 0) && w_sum[ACC_W]) ? SAT_LO : SAT_HI;
`else
  assign w_sum_sat = r_acc + w_prod;
  assign w_sum_ovf = 1'b0;
`endif

  always_comb begin
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf;
    if (ce && w_acc_fire) begin
      if (w_acc_first) begin
        w_acc_nxt = w_prod;
        w_ovf_nxt = 1'b0;
      end else begin
        w_acc_nxt = w_sum_sat;
        w_ovf_nxt = r_ovf | w_sum_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_south      <= '0;
      r_south_vld  <= 1'b0;
      r_east       <= '0;
      r_east_vld   <= 1'b0;
      r_east_first <= 1'b0;
    end else if (ce) begin
      r_south      <= north_in;
      r_south_vld  <= north_vld;
      r_east       <= west_in;
      r_east_vld   <= west_vld;
      r_east_first <= west_first;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // Capture takes the post-update accumulator so a product landing this cycle is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
    end else if (ce) begin
      if (cap) begin
        r_result <= w_acc_nxt;
      end else if (drain_shift) begin
        r_result <= drain_in;
      end
    end
  end

  assign south_out  = r_south;
  assign south_vld  = r_south_vld;
  assign east_out   = r_east;
  assign east_vld   = r_east_vld;
  assign east_first = r_east_first;
  assign result     = r_result;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_mac_pe_os.sv
// Bench for mac_pe_os: six PEs (two pipeline depths, a 32-bit accumulator, a 3-PE drain column)
// sharing one stimulus stream, checked every cycle against an arithmetic model.
module tb_mac_pe_os;

  localparam int N = 6;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, north_vld, west_vld, west_first, cap, drain_shift;
  logic [15:0] north_in, west_in;

  logic [15:0] win  [N];
  logic [15:0] sout [N];
  logic [15:0] eout [N];
  logic        svld [N];
  logic        evld [N];
  logic        efst [N];
  logic        ovf  [N];
  logic [39:0] res  [N];
  logic [39:0] din  [N];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // 0: pipe0/acc40, 1: pipe1/acc40, 2: pipe0/acc32, 3..5: drain column top to bottom.
  for (genvar g = 0; g < N; g++) begin : g_pe
    localparam int AW = (g == 2) ? 32 : 40;
    localparam int MP = (g == 1) ? 1 : 0;
    logic [AW-1:0] w_res;

    if (g >= 3) begin : g_wm
      assign win[g] = 16'(west_in * 16'(g - 2));
    end else begin : g_w1
      assign win[g] = west_in;
    end
    if (g >= 4) begin : g_dc
      assign din[g] = res[g-1];
    end else begin : g_d0
      assign din[g] = '0;
    end
    assign res[g] = 40'(w_res);

    mac_pe_os #(.DATA_W(16), .ACC_W(AW), .SIGNED(1), .MUL_PIPE(MP)) u_dut (
      .clk(clk), .rst(rst), .ce(ce),
      .north_in(north_in), .north_vld(north_vld),
      .west_in(win[g]), .west_vld(west_vld), .west_first(west_first),
      .south_out(sout[g]), .south_vld(svld[g]),
      .east_out(eout[g]), .east_vld(evld[g]), .east_first(efst[g]),
      .cap(cap), .drain_shift(drain_shift), .drain_in(AW'(din[g])),
      .result(w_res), .ovf(ovf[g])
    );
  end

  // ---------------- model ----------------
  longint      m_acc  [N];
  logic [39:0] m_res  [N];
  bit          m_ovf  [N];
  bit          s_fire [N];
  bit          s_first[N];
  longint      s_prod [N];
  logic [15:0] m_sout [N];
  logic [15:0] m_eout [N];
  bit          m_svld [N];
  bit          m_evld [N];
  bit          m_efst [N];

  function automatic int aw_of(input int i);
    return (i == 2) ? 32 : 40;
  endfunction

  function automatic longint wrap_to(input longint v, input int aw);
    longint sh;
    sh = 64 - aw;
    return (v <<< sh) >>> sh;
  endfunction

  function automatic logic [39:0] bits_of(input longint v, input int aw);
    logic [39:0] b;
    b = 40'(v);
    if (aw < 40) b = b & ((40'd1 << aw) - 40'd1);
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    longint p, q, s;
    bit     f, fst;
    int     aw;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_acc[i] = 0; m_res[i] = '0; m_ovf[i] = 0;
        s_fire[i] = 0; s_first[i] = 0; s_prod[i] = 0;
        m_sout[i] = '0; m_eout[i] = '0; m_svld[i] = 0; m_evld[i] = 0; m_efst[i] = 0;
      end
    end else if (ce) begin
      // Bottom-up so each drain sees its northern neighbour's previous result.
      for (int i = N - 1; i >= 0; i--) begin
        aw = aw_of(i);
        p  = longint'($signed(north_in)) * longint'($signed(win[i]));
        if (i == 1) begin
          f = s_fire[i]; fst = s_first[i]; q = s_prod[i];
          s_fire[i] = north_vld && west_vld; s_first[i] = west_first; s_prod[i] = p;
        end else begin
          f = north_vld && west_vld; fst = west_first; q = p;
        end
        if (f) begin
          if (fst) begin
            m_acc[i] = q; m_ovf[i] = 0;
          end else begin
            s = m_acc[i] + q;
`ifdef MAC_SAT_EN
            if (s > (longint'(1) <<< (aw - 1)) - 1) begin
              s = (longint'(1) <<< (aw - 1)) - 1; m_ovf[i] = 1;
            end else if (s < -(longint'(1) <<< (aw - 1))) begin
              s = -(longint'(1) <<< (aw - 1)); m_ovf[i] = 1;
            end
`else
            s = wrap_to(s, aw);
`endif
            m_acc[i] = s;
          end
        end
        if (cap) m_res[i] = bits_of(m_acc[i], aw);
        else if (drain_shift) begin
          if (i >= 4) m_res[i] = m_res[i-1];
          else        m_res[i] = '0;
        end
        m_sout[i] = north_in; m_svld[i] = north_vld;
        m_eout[i] = win[i];   m_evld[i] = west_vld; m_efst[i] = west_first;
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s pe%0d got %h expected %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        chk("south_out",  i, 40'(sout[i]), 40'(m_sout[i]));
        chk("south_vld",  i, 40'(svld[i]), 40'(m_svld[i]));
        chk("east_out",   i, 40'(eout[i]), 40'(m_eout[i]));
        chk("east_vld",   i, 40'(evld[i]), 40'(m_evld[i]));
        chk("east_first", i, 40'(efst[i]), 40'(m_efst[i]));
        chk("result",     i, res[i], m_res[i]);
        chk("ovf",        i, 40'(ovf[i]), 40'(m_ovf[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit nv, input logic [15:0] n, input bit wv, input logic [15:0] w,
                       input bit fst, input bit c, input bit d);
    north_vld = nv; north_in = n; west_vld = wv; west_in = w;
    west_first = fst; cap = c; drain_shift = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; ce = 1'b1;
    north_vld = 0; north_in = '0; west_vld = 0; west_in = '0;
    west_first = 0; cap = 0; drain_shift = 0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_result", 0, res[0], 40'd0);
    chk("rst_svld",   0, 40'(svld[0]), 40'd0);
    chk("rst_ovf",    2, 40'(ovf[2]), 40'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // First pair resets, second accumulates: 12 then 12-10=2.
    drive(1, 16'd3, 1, 16'd4, 1, 0, 0);
    drive(1, 16'hFFFE, 1, 16'd5, 0, 1, 0);
    chk("cap_same_cycle_p0", 0, res[0], 40'd2);
    chk("cap_same_cycle_p1", 1, res[1], 40'd12);
    drive(0, 16'd0, 0, 16'd0, 0, 1, 0);
    chk("cap_p0", 0, res[0], 40'd2);
    chk("cap_p1", 1, res[1], 40'd2);

    // Lone north valid: forwarded, never accumulated.
    drive(1, 16'd9, 0, 16'd0, 0, 0, 0);
    chk("skew_south", 0, 40'(sout[0]), 40'd9);
    chk("skew_svld",  0, 40'(svld[0]), 40'd1);
    drive(1, 16'd9, 0, 16'd0, 0, 0, 0);
    drive(0, 16'd0, 0, 16'd0, 0, 1, 0);
    chk("skew_acc_p0", 0, res[0], 40'd2);
    chk("skew_acc_p1", 1, res[1], 40'd2);

    drive(1, 16'd7, 1, 16'd6, 1, 0, 0);
    drive(0, 16'd0, 0, 16'd0, 0, 1, 0);
    chk("pipe_42", 1, res[1], 40'd42);

    // Clock-enable stall mid-tile: 2 + 12 + 30 = 44.
    drive(1, 16'd1, 1, 16'd2, 1, 0, 0);
    drive(1, 16'd3, 1, 16'd4, 0, 0, 0);
    ce = 1'b0;
    repeat (3) drive(1, 16'd100, 1, 16'd100, 1, 1, 1);
    chk("frozen_south", 0, 40'(sout[0]), 40'd3);
    chk("frozen_res",   0, res[0], 40'd42);
    ce = 1'b1;
    drive(1, 16'd5, 1, 16'd6, 0, 0, 0);
    drive(0, 16'd0, 0, 16'd0, 0, 1, 0);
    chk("resume_p0", 0, res[0], 40'd44);
    chk("resume_p1", 1, res[1], 40'd44);

    // Column holds 10/20/30; bottom PE drains 30,20,10,0.
    drive(1, 16'd10, 1, 16'd1, 1, 0, 0);
    drive(0, 16'd0, 0, 16'd0, 0, 1, 0);
    chk("col_top", 3, res[3], 40'd10);
    chk("col_bot", 5, res[5], 40'd30);
    drive(0, 16'd0, 0, 16'd0, 0, 0, 1);
    chk("drain1", 5, res[5], 40'd20);
    drive(0, 16'd0, 0, 16'd0, 0, 0, 1);
    chk("drain2", 5, res[5], 40'd10);
    drive(0, 16'd0, 0, 16'd0, 0, 0, 1);
    chk("drain3", 5, res[5], 40'd0);

    // Three products of 2^30 into a 32-bit signed accumulator.
    drive(1, 16'h8000, 1, 16'h8000, 1, 0, 0);
    repeat (2) drive(1, 16'h8000, 1, 16'h8000, 0, 0, 0);
    drive(0, 16'd0, 0, 16'd0, 0, 1, 0);
`ifdef MAC_SAT_EN
    chk("sat_res", 2, res[2], 40'h007FFFFFFF);
    chk("sat_ovf", 2, 40'(ovf[2]), 40'd1);
`else
    chk("wrap_res", 2, res[2], 40'h00C0000000);
    chk("wrap_ovf", 2, 40'(ovf[2]), 40'd0);
`endif
    chk("wide_res", 0, res[0], 40'h00C0000000);
    drive(1, 16'd1, 1, 16'd1, 1, 0, 0);
    chk("first_clears_ovf", 2, 40'(ovf[2]), 40'd0);

    // Asynchronous reset mid-tile.
    drive(1, 16'd5, 1, 16'd5, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_res",   0, res[0], 40'd0);
    chk("arst_south", 0, 40'(sout[0]), 40'd0);
    chk("arst_svld",  0, 40'(svld[0]), 40'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    drive(0, 16'd0, 0, 16'd0, 0, 1, 0);
    chk("post_rst_acc", 1, res[1], 40'd0);
    drive(0, 16'd0, 0, 16'd0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
